// File: rtl/alu_issue_if.sv
// Instruction and result handshake bundle for the alu_issue front end.
// The slave side is the issue block; the master side is fetch plus the
// downstream result consumer.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_rd;

    modport master (
        output in_valid, in_instr, res_ready,
        input  in_ready, res_valid, res_data, res_rd
    );

    modport slave (
        input  in_valid, in_instr, res_ready,
        output in_ready, res_valid, res_data, res_rd
    );
endinterface

// File: rtl/alu_issue.sv
// Two-stage issue/writeback front end for the external combinational ALU.
// Stage 1 holds the decoded operands that drive the ALU.
// Stage 2 captures the ALU result, writes it back and offers it downstream.
// Source operands that match the in-flight destination are forwarded from
// alu_out, so the pipeline never stalls on data hazards.
module alu_issue #(
    parameter int NREGS = 8,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_if.slave      bus,
    output logic [3:0]      alu_ctrl,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    input  logic [31:0]     alu_out,
    output logic [CNTW-1:0] retired
);

    logic [31:0] regs [NREGS];

    logic        iss_valid;
    logic [2:0]  iss_rd;

    logic        res_valid;
    logic [31:0] res_data;
    logic [2:0]  res_rd;

    logic [3:0]  dec_op;
    logic [2:0]  dec_rd;
    logic        dec_imm;
    logic [7:0]  dec_imm8;
    logic [2:0]  dec_rb;

    logic [31:0] opnd_a;
    logic [31:0] opnd_b;

    logic        s2_free;
    logic        s1_adv;
    logic        in_ready;
    logic        take;

    assign dec_op   = bus.in_instr[15:12];
    assign dec_rd   = bus.in_instr[11:9];
    assign dec_imm  = bus.in_instr[8];
    assign dec_imm8 = bus.in_instr[7:0];
    assign dec_rb   = bus.in_instr[2:0];

    // Handshake terms depend only on registered state and res_ready.
    assign s2_free  = !res_valid || bus.res_ready;
    assign s1_adv   = iss_valid && s2_free;
    assign in_ready = !iss_valid || s2_free;
    assign take     = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_rd    = res_rd;

    // Operand fetch, bypassing the register file when stage 1 writes the source.
    always_comb begin
        opnd_a = regs[dec_rd];
        if (iss_valid && (iss_rd == dec_rd)) begin
            opnd_a = alu_out;
        end
        if (dec_imm) begin
            opnd_b = {24'b0, dec_imm8};
        end else if (iss_valid && (iss_rd == dec_rb)) begin
            opnd_b = alu_out;
        end else begin
            opnd_b = regs[dec_rb];
        end
    end

    // Stage 1: latch the decoded instruction; ALU outputs hold until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_rd    <= '0;
            alu_ctrl  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else if (take) begin
            iss_valid <= 1'b1;
            iss_rd    <= dec_rd;
            alu_ctrl  <= dec_op;
            alu_a     <= opnd_a;
            alu_b     <= opnd_b;
        end else if (s1_adv) begin
            iss_valid <= 1'b0;
        end
    end

    // Stage 2: capture the ALU result when stage 1 advances, drop it once taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
        end else if (s1_adv) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_rd    <= iss_rd;
        end else if (bus.res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Register file write-back on the same edge stage 2 captures the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (s1_adv) begin
            regs[iss_rd] <= alu_out;
        end
    end

    // Count results accepted downstream; wraps naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (res_valid && bus.res_ready) begin
            retired <= retired + CNTW'(1);
        end
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/writeback front end for the 32-bit ALU. It accepts 16-bit two-address instructions over a valid/ready handshake and decodes each one into the ALU's 4-bit control code and A/B operands. It reads operands from an internal 8×32 register file, forwarding where needed. It captures the ALU result, writes it back to the destination register and presents it on a result handshake. The block sits between instruction fetch and the combinational ALU; the ALU itself stays outside the block and is wired to the `alu_*` ports.

## Interface
- `NREGS`, 8: register file depth. Fixed at 8 because of the 3-bit register fields.
- `CNTW`, 16: width of the retire counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: instruction valid.
- `in_ready`, out, 1: block accepts the instruction this cycle.
- `in_instr`, in, 16: instruction word, format below.
- `alu_ctrl`, out, 4: control code driven to the ALU.
- `alu_a`, out, 32: ALU operand A.
- `alu_b`, out, 32: ALU operand B.
- `alu_out`, in, 32: combinational ALU result for the current `alu_*` values.
- `res_valid`, out, 1: result valid.
- `res_ready`, in, 1: downstream accepts the result.
- `res_data`, out, 32: result value.
- `res_rd`, out, 3: destination register of the result.
- `retired`, out, CNTW: count of results accepted downstream.

## Operation
- Instruction fields:
  - `op[15:12]`: copied verbatim to `alu_ctrl`.
  - `rd[11:9]`: destination register.
  - `I[8]`: immediate select.
  - `I=1`: `imm8[7:0]`.
  - `I=0`: `rb[2:0]`; bits `[7:3]` are ignored.
- Operands:
  - `A = R[rd]`.
  - `B = I ? {24'b0, imm8} : R[rb]`.
  - The result always writes `R[rd]`.
- ALU semantics the verification model uses:
  - 0000–0011: byte-lane insert of `B[7:0]` into A, lane 3 down to lane 0.
  - 0101: `B >> A[4:0]`.
  - 0110: rotate right.
  - 0111: arithmetic shift right.
  - 1000: rotate left.
  - 1001: `~B`.
  - 1010: xor.
  - 1011: or.
  - 1100: and.
  - 1101: `B − A`.
  - 1110: `A + B`.
  - 0100 and 1111: pass B.
  - No left-shift opcode exists. The decoder never remaps opcodes.
- Arithmetic is modulo 2^32. No flags are produced.
- Stage 1 (issue register), loaded on `in_valid && in_ready`:
  - Holds `iss_valid`, `alu_ctrl`, `alu_a`, `alu_b` and `iss_rd`.
  - The `alu_*` outputs are driven directly from these registers.
- Stage 2 (result register), loaded when stage 1 advances:
  - Holds `res_valid`, `res_data` and `res_rd`.
  - `res_data` captures `alu_out`.
  - `R[iss_rd]` is written with `alu_out` on the same edge.
- Advance rules:
  - `s2_free = !res_valid || res_ready`.
  - `s1_adv = iss_valid && s2_free`.
  - `in_ready = !iss_valid || s2_free`.
  - Both `in_ready` and `s1_adv` are purely combinational from the registered state and `res_ready`. There is no path from `in_valid`.
- Forwarding:
  - When `iss_valid` and `iss_rd` matches a source register of the incoming instruction (`rd` for A; `rb` for B when `I=0`), that operand is taken from `alu_out` instead of the register file.
  - This covers every RAW hazard. The block never stalls for hazards.
- Registers and outputs hold their values when not loaded.
- `retired` increments on `res_valid && res_ready` and wraps from 2^CNTW−1 to 0.

## Timing
- Reset values: all `R[i] = 0`; `in_ready = 1`; `alu_ctrl = 0`; `alu_a = 0`; `alu_b = 0`; `res_valid = 0`; `res_data = 0`; `res_rd = 0`; `retired = 0`. The internal `iss_valid` also resets to 0.
- Reset mid-operation: in-flight instructions are discarded. Partial writeback does not occur.
- Latency and throughput:
  - Instruction accepted at edge N: `alu_*` is valid through cycle N+1.
  - `res_valid` rises at edge N+1 when stage 2 is free.
  - `R[rd]` is updated at edge N+1.
  - Throughput is one instruction per cycle with `res_ready` held high.
- Backpressure:
  - With `res_ready = 0`, at most two instructions are held (stage 1 and stage 2).
  - `in_ready` drops in the cycle both stages are full.
  - `res_data`, `res_rd` and the `alu_*` outputs stay stable while stalled.
- The handshake permits a simultaneous `res_ready` and `in_valid` in a full pipeline: stage 2 drains, stage 1 advances and a new instruction loads, all on one edge.
- Back-to-back writes to the same `rd`: the later instruction sees the earlier result through forwarding. Register-file order equals program order.

## Test plan
- Reset, then:
  - 0x3305 (insert lane 0, R1, imm 0x05): `res_data = 0x00000005`, `res_rd = 1` two edges after acceptance.
  - 0x0580 (insert lane 3, R2, imm 0x80): `res_data = 0x80000000`.
- Dependent pair with `res_ready = 1` streaming:
  - 0x3305, then 0xE201 (add, R1, rb=R1, forwarded): `res_data = 0x0000000A`.
  - Then 0xD201 (sub, R1 − R1): `res_data = 0`.
  - `in_ready` stays at 1 throughout.
- Shift and rotate with R1 = 4 via 0x3304:
  - 0x6380 (ror, R1, imm 0x80): `B = 0x80`, `A = 4`, `res_data = 0x00000008`.
  - Then 0x0380 (insert lane 3): `res_data = 0x80000008`.
- Backpressure:
  - Hold `res_ready = 0` and offer three instructions back-to-back: exactly two are accepted, `in_ready` = 0 from the third cycle on, and `res_data` stays stable.
  - Release `res_ready`: all three results appear in order and `retired = 3`.
- Reset mid-flight: assert `rst_n = 0` while both stages are full. Every output returns to its reset value immediately, and a subsequent 0xE201 yields `res_data = 0`.
- Counter wrap: with `CNTW = 4`, retire 17 results and check `retired = 1`.
